uart_tx_ctrl: RTL

UART transmit sequencer driven by the one-cycle baud tick from the TX baud divider (one tick every 652 i_clk cycles).
- Accepts a byte over a valid/ready handshake.
- Aligns the frame to the next baud tick, then shifts out start, data (LSB first), optional parity and stop bits, one bit per tick.
- Sits between the host-side byte source and the serial TX pin.

---
 rtl/uart_pkg.sv | 35 +++
 rtl/uart_tx_ctrl.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
//
// Purpose:
//   Shared definitions for the UART blocks: the transmit sequencer state
//   encoding, default frame format and the baud divisor used by the TX and
//   RX baud dividers.
//
// Contents:
//   tx_state_e        - 3-bit state encoding of the TX sequencer
//   DEFAULT_DATA_W    - default number of data bits per frame
//   DEFAULT_STOP_BITS - default number of stop bits per frame
//   BAUD_DIV          - i_clk cycles per baud period (one tick per period)
// ---------------------------------------------------------------------------
package uart_pkg;

    // Sequencer states. The encodings are fixed so that waveform viewers and
    // any debug readback see the same values in every build.
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ALIGN  = 3'd1,
        ST_START  = 3'd2,
        ST_DATA   = 3'd3,
        ST_PARITY = 3'd4,
        ST_STOP   = 3'd5
    } tx_state_e;

    localparam int DEFAULT_DATA_W    = 8;
    localparam int DEFAULT_STOP_BITS = 1;

    // One baud tick every BAUD_DIV system clocks; the TX and RX dividers
    // both count to this value so the two directions stay matched.
    localparam int BAUD_DIV = 652;

endpackage : uart_pkg

// File: rtl/uart_tx_ctrl.sv
// ---------------------------------------------------------------------------
// uart_tx_ctrl
//
// Purpose:
//   UART transmit sequencer. Takes one byte at a time over a valid/ready
//   handshake, waits for the next baud tick to align the frame, then shifts
//   out start bit, data bits (LSB first), an optional parity bit and one or
//   two stop bits, advancing one bit per baud tick.
//
// Parameters:
//   DATA_W     - data bits per frame (5..9)
//   PARITY_EN  - 1 inserts a parity bit after the data bits
//   PARITY_ODD - 0 even parity, 1 odd parity (unused when PARITY_EN = 0)
//   STOP_BITS  - stop bits per frame (1 or 2)
//
// Ports:
//   i_clk       - system clock
//   i_reset     - asynchronous, active-low reset
//   i_baud_tick - one-cycle baud strobe from the TX baud divider
//   i_valid     - a byte is available on i_data
//   i_data      - byte to transmit
//   o_ready     - controller can accept a byte this cycle
//   o_tx        - serial line, idles high
//   o_busy      - a frame is in progress
//   o_done      - one-cycle pulse after the last stop bit has completed
//
// All outputs come straight from flops, so a tick sampled on one edge
// changes the line on that same edge and is visible in the next cycle.
// ---------------------------------------------------------------------------
module uart_tx_ctrl
    import uart_pkg::*;
#(
    parameter int DATA_W     = DEFAULT_DATA_W,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0,
    parameter int STOP_BITS  = DEFAULT_STOP_BITS
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_baud_tick,
    input  logic              i_valid,
    input  logic [DATA_W-1:0] i_data,
    output logic              o_ready,
    output logic              o_tx,
    output logic              o_busy,
    output logic              o_done
);

    // bit_cnt only has to reach DATA_W-1, so clog2(DATA_W) bits suffice and
    // it never wraps inside a frame.
    localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(DATA_W - 1);

    // stop_cnt is a single bit: with one stop bit the first stop tick is
    // already the last one, with two stop bits the second one is.
    localparam logic STOP_LAST = (STOP_BITS > 1);

    localparam logic PAR_EN  = (PARITY_EN != 0);
    localparam logic PAR_ODD = (PARITY_ODD != 0);

    tx_state_e         state_q,    state_d;
    logic [DATA_W-1:0] shift_q,    shift_d;
    logic              parity_q,   parity_d;
    logic [CNT_W-1:0]  bit_cnt_q,  bit_cnt_d;
    logic              stop_cnt_q, stop_cnt_d;
    logic              tx_q,       tx_d;
    logic              ready_q,    ready_d;
    logic              busy_q,     busy_d;
    logic              done_q,     done_d;

    // State and datapath registers. Reset drives the line high straight away
    // so a frame interrupted during a low bit releases the line at once
    // instead of waiting for a clock edge.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state_q    <= ST_IDLE;
            shift_q    <= '0;
            parity_q   <= 1'b0;
            bit_cnt_q  <= '0;
            stop_cnt_q <= 1'b0;
            tx_q       <= 1'b1;
            ready_q    <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            parity_q   <= parity_d;
            bit_cnt_q  <= bit_cnt_d;
            stop_cnt_q <= stop_cnt_d;
            tx_q       <= tx_d;
            ready_q    <= ready_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    // Next-state and next-output logic. Everything holds its value by
    // default and only moves on a baud tick, except the accept path in IDLE
    // which reacts to the handshake on any cycle. A tick arriving in the
    // accept cycle belongs to IDLE and is deliberately not used: the frame
    // always waits in ALIGN for a fresh tick, so every bit, including the
    // start bit, lasts exactly one full tick period.
    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        parity_d   = parity_q;
        bit_cnt_d  = bit_cnt_q;
        stop_cnt_d = stop_cnt_q;
        tx_d       = tx_q;
        ready_d    = ready_q;
        busy_d     = busy_q;
        done_d     = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                // Parity is computed once here from the latched byte, so the
                // shifting register does not have to be re-examined later.
                if (i_valid && ready_q) begin
                    shift_d  = i_data;
                    parity_d = (^i_data) ^ PAR_ODD;
                    ready_d  = 1'b0;
                    busy_d   = 1'b1;
                    state_d  = ST_ALIGN;
                end
            end

            ST_ALIGN: begin
                if (i_baud_tick) begin
                    tx_d    = 1'b0;
                    state_d = ST_START;
                end
            end

            ST_START: begin
                if (i_baud_tick) begin
                    tx_d      = shift_q[0];
                    bit_cnt_d = '0;
                    state_d   = ST_DATA;
                end
            end

            ST_DATA: begin
                // The bit on the line is always shift_q[0]; on each tick the
                // register moves down one place and shift_q[1] goes out next.
                if (i_baud_tick) begin
                    if (bit_cnt_q == BIT_LAST) begin
                        if (PAR_EN) begin
                            tx_d    = parity_q;
                            state_d = ST_PARITY;
                        end else begin
                            tx_d       = 1'b1;
                            stop_cnt_d = 1'b0;
                            state_d    = ST_STOP;
                        end
                    end else begin
                        shift_d   = shift_q >> 1;
                        tx_d      = shift_q[1];
                        bit_cnt_d = bit_cnt_q + CNT_W'(1);
                    end
                end
            end

            ST_PARITY: begin
                if (i_baud_tick) begin
                    tx_d       = 1'b1;
                    stop_cnt_d = 1'b0;
                    state_d    = ST_STOP;
                end
            end

            ST_STOP: begin
                // o_ready rises together with o_done, so a source that
                // presents its next byte during the done pulse is accepted
                // in that same cycle and no byte slot is lost.
                if (i_baud_tick) begin
                    if (stop_cnt_q == STOP_LAST) begin
                        done_d  = 1'b1;
                        ready_d = 1'b1;
                        busy_d  = 1'b0;
                        state_d = ST_IDLE;
                    end else begin
                        stop_cnt_d = 1'b1;
                    end
                end
            end

            default: begin
                // Unused encodings fall back to a clean idle line.
                tx_d    = 1'b1;
                ready_d = 1'b1;
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    assign o_tx    = tx_q;
    assign o_ready = ready_q;
    assign o_busy  = busy_q;
    assign o_done  = done_q;

endmodule : uart_tx_ctrl
